bp_cce_mem_traffic_gen: RTL and testbench
=========================================

// Module: bp_cce_mem_traffic_gen
// PURPOSE
//  CCE-side initiator for the CCE<->memory interface, used standalone to exercise bp_mem without a core.
//  Writes a deterministic pattern to num_ops_p blocks via mem_data_cmd, reads every block back via mem_cmd,
//  checks each mem_data_resp, and reports pass/fail. Sits where bp_multi_top's CCE mem ports normally sit.
// PARAMETERS
//  paddr_width_p            22     physical address width
//  num_lce_p                1      LCE count (sizes struct lce_id fields)
//  lce_assoc_p              8      associativity (sizes struct way_id fields)
//  block_size_in_bits_p     512    cache block width; multiple of 64
//  num_ops_p                16     blocks written then read; >=1
//  base_addr_p              0      address of block 0; block-aligned
//  timeout_p                1024   max cycles waiting on any single response
// PORTS
//  clk_i                 in   1    clock
//  reset_n_i             in   1    asynchronous active-low reset
//  start_i               in   1    pulse in IDLE launches a run
//  mem_cmd_o             out  bp_cce_mem_cmd_width       read command (bp_cce_mem_cmd_s)
//  mem_cmd_v_o           out  1    mem_cmd_o valid
//  mem_cmd_yumi_i        in   1    memory consumes mem_cmd_o
//  mem_data_cmd_o        out  bp_cce_mem_data_cmd_width  write command + block data (bp_cce_mem_data_cmd_s)
//  mem_data_cmd_v_o      out  1    mem_data_cmd_o valid
//  mem_data_cmd_yumi_i   in   1    memory consumes mem_data_cmd_o
//  mem_resp_i            in   bp_mem_cce_resp_width      write ack (bp_mem_cce_resp_s)
//  mem_resp_v_i          in   1    write ack valid
//  mem_resp_ready_o      out  1    ready for write ack
//  mem_data_resp_i       in   bp_mem_cce_data_resp_width read data (bp_mem_cce_data_resp_s)
//  mem_data_resp_v_i     in   1    read data valid
//  mem_data_resp_ready_o out  1    ready for read data
//  busy_o                out  1    run in progress
//  done_o                out  1    run finished (sticky until next start_i)
//  error_o               out  1    mismatch or timeout seen (sticky until next start_i)
//  err_cnt_o             out  16   mismatching blocks, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state=IDLE; all v_o/ready_o=0; busy_o=done_o=error_o=0; err_cnt_o=0; op idx=0.
//  Op k: addr = base_addr_p + k*(block_size_in_bits_p/8); lce_id=0; way_id = k mod lce_assoc_p.
//   Data word w (64b, w=0 at LSB) = {32'(k), 32'(w)}.
//  FSM: IDLE -start_i-> WR_SEND -> WR_WAIT -> (k<num_ops_p-1: WR_SEND k+1; else RD_SEND k=0)
//       RD_SEND -> RD_WAIT -> (k<num_ops_p-1: RD_SEND k+1; else DONE); any WAIT timeout -> FAIL.
//  On start_i: clear done_o, error_o, err_cnt_o, k=0; busy_o=1 in every state except IDLE/DONE/FAIL.
//  WR_SEND: mem_data_cmd_v_o=1, payload stable until mem_data_cmd_yumi_i; yumi -> WR_WAIT next cycle.
//  WR_WAIT: mem_resp_ready_o=1; mem_resp_v_i & ready consumes ack; addr mismatch counts as error.
//  RD_SEND: mem_cmd_v_o=1, msg_type=read, held until mem_cmd_yumi_i.
//  RD_WAIT: mem_data_resp_ready_o=1; on handshake compare addr and full block vs expected;
//   any bit mismatch -> err_cnt_o+1 (saturating), error_o=1; run continues.
//  Exactly one command outstanding; never v_o on both command channels in one cycle.
//  v_o never deasserts before yumi; yumi without v_o is ignored.
//  Timeout: per-wait counter cleared on WAIT entry; reaching timeout_p -> FAIL: error_o=1, done_o=1,
//   err_cnt_o unchanged, all v_o/ready_o=0. FAIL and DONE return to WR_SEND only on start_i.
//  DONE: done_o=1, busy_o=0. start_i while busy_o=1 ignored.
//  Responses arriving in a non-WAIT state are not accepted (ready_o=0).
//  Reset mid-run: immediate abort to reset values; no partial command asserted afterwards.
//  Latency: first mem_data_cmd_v_o 1 cycle after start_i; next op SEND 1 cycle after response handshake.
// TESTING
//  1 bp_mem, num_ops_p=4, start_i pulse -> 4 writes at 0x0,0x40,0x80,0xC0 then 4 reads; done_o=1, err_cnt_o=0.
//  2 Responder corrupts bit 0 of block 2 read data -> done_o=1, error_o=1, err_cnt_o=1; other blocks pass.
//  3 yumi_i held low 5 cycles on op 0 -> payload stable all 5 cycles, single command issued, run passes.
//  4 Responder drops write ack of op 1, timeout_p=16 -> FAIL after 16 cycles in WR_WAIT, done_o=error_o=1.
//  5 reset_n_i low during RD_WAIT of op 2 -> all outputs 0 immediately; fresh start_i completes clean.
//  6 start_i while busy_o=1, and back-to-back runs -> ignored mid-run; second run clears flags, passes again.

Source files
------------

// File: rtl/bp_cce_mem_traffic_gen.sv
// ---------------------------------------------------------------------------
// bp_cce_mem_traffic_gen
//
// Stand-alone CCE-side initiator for the CCE<->memory interface. The block
// writes a deterministic pattern to num_ops_p consecutive cache blocks through
// mem_data_cmd and then reads every block back through mem_cmd. It compares
// each returned block against the pattern and reports the result on
// done_o/error_o/err_cnt_o. Only one command is ever outstanding.
//
// Message layouts (packed, MSB first):
//   mem_cmd_o        : {msg_type, addr, lce_id, way_id}
//   mem_data_cmd_o   : {msg_type, addr, lce_id, way_id, data[block]}
//   mem_resp_i       : {msg_type, addr, lce_id, way_id}
//   mem_data_resp_i  : {msg_type, addr, lce_id, way_id, data[block]}
//   msg_type         : 0 = read, 1 = write
//
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   start_i                           launches a run when the block is not busy
//   mem_cmd_o/_v_o/_yumi_i            read command channel
//   mem_data_cmd_o/_v_o/_yumi_i       write command + block data channel
//   mem_resp_i/_v_i/_ready_o          write acknowledge channel
//   mem_data_resp_i/_v_i/_ready_o     read data channel
//   busy_o                            run in progress
//   done_o                            run finished (sticky until next start)
//   error_o                           mismatch or timeout seen (sticky)
//   err_cnt_o                         mismatching responses, saturating
// ---------------------------------------------------------------------------
module bp_cce_mem_traffic_gen #(
  parameter int unsigned paddr_width_p        = 22,
  parameter int unsigned num_lce_p            = 1,
  parameter int unsigned lce_assoc_p          = 8,
  parameter int unsigned block_size_in_bits_p = 512,
  parameter int unsigned num_ops_p            = 16,
  parameter int unsigned base_addr_p          = 0,
  parameter int unsigned timeout_p            = 1024,
  localparam int unsigned lce_id_width_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int unsigned way_id_width_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int unsigned bp_cce_mem_cmd_width =
    1 + paddr_width_p + lce_id_width_lp + way_id_width_lp,
  localparam int unsigned bp_cce_mem_data_cmd_width =
    bp_cce_mem_cmd_width + block_size_in_bits_p,
  localparam int unsigned bp_mem_cce_resp_width      = bp_cce_mem_cmd_width,
  localparam int unsigned bp_mem_cce_data_resp_width = bp_cce_mem_data_cmd_width
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  start_i,

  output logic [bp_cce_mem_cmd_width-1:0]       mem_cmd_o,
  output logic                                  mem_cmd_v_o,
  input  logic                                  mem_cmd_yumi_i,

  output logic [bp_cce_mem_data_cmd_width-1:0]  mem_data_cmd_o,
  output logic                                  mem_data_cmd_v_o,
  input  logic                                  mem_data_cmd_yumi_i,

  input  logic [bp_mem_cce_resp_width-1:0]      mem_resp_i,
  input  logic                                  mem_resp_v_i,
  output logic                                  mem_resp_ready_o,

  input  logic [bp_mem_cce_data_resp_width-1:0] mem_data_resp_i,
  input  logic                                  mem_data_resp_v_i,
  output logic                                  mem_data_resp_ready_o,

  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic [15:0]                           err_cnt_o
);

  localparam int unsigned idx_width_lp   = (num_ops_p > 1) ? $clog2(num_ops_p) : 1;
  localparam int unsigned tmr_width_lp   = $clog2(timeout_p + 1);
  localparam int unsigned words_lp       = block_size_in_bits_p / 64;
  localparam int unsigned block_bytes_lp = block_size_in_bits_p / 8;
  localparam int unsigned hdr_width_lp   = bp_cce_mem_cmd_width;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SEND,
    S_WR_WAIT,
    S_RD_SEND,
    S_RD_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                    state_q, state_d;
  logic [idx_width_lp-1:0]   idx_q, idx_d;
  logic [tmr_width_lp-1:0]   tmr_q, tmr_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [15:0]               err_cnt_q, err_cnt_d;

  logic [paddr_width_p-1:0]        addr_exp;
  logic [way_id_width_lp-1:0]      way_exp;
  logic [block_size_in_bits_p-1:0] data_exp;
  logic [hdr_width_lp-1:0]         wr_hdr, rd_hdr;
  logic                            last_op;
  logic                            tmr_expired;
  logic                            wr_ack_ok, rd_data_ok;

  // Expected message contents for the current op index.
  assign addr_exp = paddr_width_p'(base_addr_p + 32'(idx_q) * block_bytes_lp);
  assign way_exp  = way_id_width_lp'(32'(idx_q) % lce_assoc_p);

  always_comb begin
    data_exp = '0;
    for (int unsigned w = 0; w < words_lp; w++) begin
      data_exp[w*64 +: 64] = {32'(idx_q), w};
    end
  end

  assign wr_hdr = {1'b1, addr_exp, lce_id_width_lp'(0), way_exp};
  assign rd_hdr = {1'b0, addr_exp, lce_id_width_lp'(0), way_exp};

  assign last_op     = (idx_q == idx_width_lp'(num_ops_p - 1));
  assign tmr_expired = (tmr_q == tmr_width_lp'(timeout_p - 1));
  assign wr_ack_ok   = (mem_resp_i == wr_hdr);
  assign rd_data_ok  = (mem_data_resp_i == {rd_hdr, data_exp});

  // Payloads are zeroed outside their SEND state so that nothing partial is
  // visible while idle, finished or in reset.
  assign mem_data_cmd_o = (state_q == S_WR_SEND) ? {wr_hdr, data_exp} : '0;
  assign mem_cmd_o      = (state_q == S_RD_SEND) ? rd_hdr : '0;

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign err_cnt_o = err_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    idx_d                 = idx_q;
    tmr_d                 = tmr_q;
    done_d                = done_q;
    error_d               = error_q;
    err_cnt_d             = err_cnt_q;
    mem_cmd_v_o           = 1'b0;
    mem_data_cmd_v_o      = 1'b0;
    mem_resp_ready_o      = 1'b0;
    mem_data_resp_ready_o = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d   = S_WR_SEND;
          idx_d     = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_cnt_d = '0;
        end
      end

      S_WR_SEND: begin
        mem_data_cmd_v_o = 1'b1;
        if (mem_data_cmd_yumi_i) begin
          state_d = S_WR_WAIT;
          tmr_d   = '0;
        end
      end

      S_WR_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_v_i) begin
          if (!wr_ack_ok) begin
            error_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (last_op) begin
            state_d = S_RD_SEND;
            idx_d   = '0;
          end else begin
            state_d = S_WR_SEND;
            idx_d   = idx_q + idx_width_lp'(1);
          end
        end else if (tmr_expired) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmr_d = tmr_q + tmr_width_lp'(1);
        end
      end

      S_RD_SEND: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_yumi_i) begin
          state_d = S_RD_WAIT;
          tmr_d   = '0;
        end
      end

      S_RD_WAIT: begin
        mem_data_resp_ready_o = 1'b1;
        if (mem_data_resp_v_i) begin
          if (!rd_data_ok) begin
            error_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (last_op) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_SEND;
            idx_d   = idx_q + idx_width_lp'(1);
          end
        end else if (tmr_expired) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmr_d = tmr_q + tmr_width_lp'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_cce_mem_traffic_gen.sv
// ---------------------------------------------------------------------------
// Testbench for bp_cce_mem_traffic_gen: a randomized memory responder, a
// scoreboard of expected commands checked by an independent monitor, and a
// directed sequence of runs covering corruption, stalls, timeout, reset
// abort and start-while-busy.
// ---------------------------------------------------------------------------
module tb_bp_cce_mem_traffic_gen;

  localparam int unsigned PADDR = 22;
  localparam int unsigned NLCE  = 1;
  localparam int unsigned ASSOC = 8;
  localparam int unsigned BLK   = 512;
  localparam int unsigned NOPS  = 4;
  localparam int unsigned BASE  = 0;
  localparam int unsigned TMO   = 16;
  localparam int unsigned LCEW  = 1;
  localparam int unsigned WAYW  = 3;
  localparam int unsigned HDRW  = 1 + PADDR + LCEW + WAYW;
  localparam int unsigned DCMDW = HDRW + BLK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [HDRW-1:0]  mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_yumi_i = 1'b0;
  logic [DCMDW-1:0] mem_data_cmd_o;
  logic             mem_data_cmd_v_o;
  logic             mem_data_cmd_yumi_i = 1'b0;
  logic [HDRW-1:0]  mem_resp_i = '0;
  logic             mem_resp_v_i = 1'b0;
  logic             mem_resp_ready_o;
  logic [DCMDW-1:0] mem_data_resp_i = '0;
  logic             mem_data_resp_v_i = 1'b0;
  logic             mem_data_resp_ready_o;
  logic             busy_o, done_o, error_o;
  logic [15:0]      err_cnt_o;

  bp_cce_mem_traffic_gen #(
    .paddr_width_p       (PADDR),
    .num_lce_p           (NLCE),
    .lce_assoc_p         (ASSOC),
    .block_size_in_bits_p(BLK),
    .num_ops_p           (NOPS),
    .base_addr_p         (BASE),
    .timeout_p           (TMO)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (rst_n),
    .start_i              (start_i),
    .mem_cmd_o            (mem_cmd_o),
    .mem_cmd_v_o          (mem_cmd_v_o),
    .mem_cmd_yumi_i       (mem_cmd_yumi_i),
    .mem_data_cmd_o       (mem_data_cmd_o),
    .mem_data_cmd_v_o     (mem_data_cmd_v_o),
    .mem_data_cmd_yumi_i  (mem_data_cmd_yumi_i),
    .mem_resp_i           (mem_resp_i),
    .mem_resp_v_i         (mem_resp_v_i),
    .mem_resp_ready_o     (mem_resp_ready_o),
    .mem_data_resp_i      (mem_data_resp_i),
    .mem_data_resp_v_i    (mem_data_resp_v_i),
    .mem_data_resp_ready_o(mem_data_resp_ready_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .error_o              (error_o),
    .err_cnt_o            (err_cnt_o)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DCMDW-1:0] act,
                     input logic [DCMDW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PADDR-1:0] m_addr(input int k);
    return PADDR'(BASE + k * (BLK / 8));
  endfunction

  function automatic logic [WAYW-1:0] m_way(input int k);
    return WAYW'(k % ASSOC);
  endfunction

  function automatic logic [BLK-1:0] m_data(input int k);
    logic [BLK-1:0] b;
    for (int w = 0; w < BLK / 64; w++) b[w*64 +: 64] = {32'(k), 32'(w)};
    return b;
  endfunction

  typedef struct {
    logic [HDRW-1:0] hdr;
    logic [BLK-1:0]  data;
    bit              is_wr;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_expect(input int nwr, input int nrd);
    for (int k = 0; k < nwr; k++)
      exp_q.push_back('{hdr: {1'b1, m_addr(k), LCEW'(0), m_way(k)}, data: m_data(k), is_wr: 1'b1});
    for (int k = 0; k < nrd; k++)
      exp_q.push_back('{hdr: {1'b0, m_addr(k), LCEW'(0), m_way(k)}, data: '0, is_wr: 1'b0});
  endtask

  // ---------------- memory responder ----------------
  int corrupt_blk = -1;
  int drop_op     = -1;
  bit stall_op0   = 1'b0;
  bit rand_en     = 1'b1;

  typedef struct {
    logic [DCMDW-1:0] msg;
    int               dly;
  } rsp_t;

  logic [BLK-1:0] mem [logic [PADDR-1:0]];

  initial begin : responder
    bit               dfire, cfire, rfire, drfire;
    bit               hold_d, hold_c;
    int               stall_d, stall_c;
    logic [DCMDW-1:0] cap_d;
    logic [HDRW-1:0]  cap_c;
    logic [PADDR-1:0] a;
    logic [BLK-1:0]   blk;
    rsp_t             wack_q[$];
    rsp_t             rdat_q[$];
    dfire = 0; cfire = 0; rfire = 0; drfire = 0;
    hold_d = 0; hold_c = 0; stall_d = 0; stall_c = 0;
    cap_d = '0; cap_c = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mem_cmd_yumi_i = 0; mem_data_cmd_yumi_i = 0;
        mem_resp_v_i = 0; mem_data_resp_v_i = 0;
        mem_resp_i = '0; mem_data_resp_i = '0;
        dfire = 0; cfire = 0; rfire = 0; drfire = 0;
        hold_d = 0; hold_c = 0;
        wack_q.delete(); rdat_q.delete();
        continue;
      end
      if (dfire) begin
        a = cap_d[DCMDW-2 -: PADDR];
        mem[a] = cap_d[BLK-1:0];
        if (!(drop_op >= 0 && a == m_addr(drop_op)))
          wack_q.push_back('{msg: DCMDW'(cap_d[DCMDW-1 -: HDRW]), dly: int'($urandom_range(0, 3))});
      end
      if (cfire) begin
        a   = cap_c[HDRW-2 -: PADDR];
        blk = mem.exists(a) ? mem[a] : '0;
        if (corrupt_blk >= 0 && a == m_addr(corrupt_blk)) blk[0] = ~blk[0];
        rdat_q.push_back('{msg: {cap_c, blk}, dly: int'($urandom_range(0, 3))});
      end
      if (rfire)  mem_resp_v_i = 0;
      if (drfire) mem_data_resp_v_i = 0;

      mem_data_cmd_yumi_i = 0;
      mem_cmd_yumi_i      = 0;
      if (mem_data_cmd_v_o) begin
        if (!hold_d) begin
          hold_d  = 1;
          stall_d = (stall_op0 && mem_data_cmd_o[DCMDW-2 -: PADDR] == m_addr(0)) ? 5 :
                    (rand_en ? int'($urandom_range(0, 2)) : 0);
        end
        if (stall_d == 0) begin
          mem_data_cmd_yumi_i = 1; cap_d = mem_data_cmd_o; hold_d = 0;
        end else stall_d--;
      end
      if (mem_cmd_v_o) begin
        if (!hold_c) begin
          hold_c  = 1;
          stall_c = rand_en ? int'($urandom_range(0, 2)) : 0;
        end
        if (stall_c == 0) begin
          mem_cmd_yumi_i = 1; cap_c = mem_cmd_o; hold_c = 0;
        end else stall_c--;
      end

      if (!mem_resp_v_i && wack_q.size() > 0) begin
        if (wack_q[0].dly == 0) begin
          mem_resp_i = wack_q[0].msg[HDRW-1:0]; mem_resp_v_i = 1; void'(wack_q.pop_front());
        end else wack_q[0].dly--;
      end
      if (!mem_data_resp_v_i && rdat_q.size() > 0) begin
        if (rdat_q[0].dly == 0) begin
          mem_data_resp_i = rdat_q[0].msg; mem_data_resp_v_i = 1; void'(rdat_q.pop_front());
        end else rdat_q[0].dly--;
      end

      dfire  = mem_data_cmd_v_o && mem_data_cmd_yumi_i;
      cfire  = mem_cmd_v_o && mem_cmd_yumi_i;
      rfire  = mem_resp_v_i && mem_resp_ready_o;
      drfire = mem_data_resp_v_i && mem_data_resp_ready_o;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int rd_hs     = 0;
  int last_wait = 0;

  initial begin : monitor
    bit               pv_d, pv_c, need_next;
    logic [DCMDW-1:0] prev_d;
    logic [HDRW-1:0]  prev_c;
    int               rdy_run;
    exp_t             e;
    pv_d = 0; pv_c = 0; need_next = 0; rdy_run = 0;
    prev_d = '0; prev_c = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_d = 0; pv_c = 0; need_next = 0; rdy_run = 0;
        continue;
      end
      if (need_next) begin
        chk("next_op_latency", DCMDW'(mem_cmd_v_o | mem_data_cmd_v_o | done_o), DCMDW'(1));
        need_next = 0;
      end
      if (mem_cmd_v_o || mem_data_cmd_v_o)
        chk("one_cmd_channel", DCMDW'(mem_cmd_v_o & mem_data_cmd_v_o), '0);
      if (pv_d) chk("wr_payload_held", {mem_data_cmd_v_o, mem_data_cmd_o[DCMDW-2:0]},
                    {1'b1, prev_d[DCMDW-2:0]});
      if (pv_c) chk("rd_payload_held", DCMDW'({mem_cmd_v_o, mem_cmd_o}), DCMDW'({1'b1, prev_c}));

      if (mem_data_cmd_v_o && mem_data_cmd_yumi_i) begin
        if (exp_q.size() == 0) chk("unexpected_write", DCMDW'(1), '0);
        else begin
          e = exp_q.pop_front();
          chk("write_cmd", mem_data_cmd_o, {e.hdr, e.data});
        end
        pv_d = 0;
      end else begin
        pv_d = mem_data_cmd_v_o; prev_d = mem_data_cmd_o;
      end
      if (mem_cmd_v_o && mem_cmd_yumi_i) begin
        rd_hs++;
        if (exp_q.size() == 0) chk("unexpected_read", DCMDW'(1), '0);
        else begin
          e = exp_q.pop_front();
          chk("read_cmd", DCMDW'(mem_cmd_o), DCMDW'(e.hdr));
        end
        pv_c = 0;
      end else begin
        pv_c = mem_cmd_v_o; prev_c = mem_cmd_o;
      end

      if ((mem_resp_v_i && mem_resp_ready_o) || (mem_data_resp_v_i && mem_data_resp_ready_o))
        need_next = 1;
      if (mem_resp_ready_o) rdy_run++;
      else if (rdy_run > 0) begin
        last_wait = rdy_run; rdy_run = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic pulse_start();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic run_once(input string tag, input int nwr, input int nrd,
                          input bit exp_fail, input int exp_errs, input bit poke_busy);
    int n;
    push_expect(nwr, nrd);
    pulse_start();
    chk({tag, "_first_cmd"}, DCMDW'({mem_data_cmd_v_o, busy_o, done_o, error_o, err_cnt_o}),
        DCMDW'({1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
    n = 0;
    while (!done_o && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke_busy && n == 8) begin
        chk({tag, "_busy_at_poke"}, DCMDW'(busy_o), DCMDW'(1));
        pulse_start();
      end
    end
    chk({tag, "_done"}, DCMDW'(done_o), DCMDW'(1));
    @(negedge clk);
    chk({tag, "_status"},
        DCMDW'({error_o, err_cnt_o, busy_o, mem_cmd_v_o, mem_data_cmd_v_o,
                mem_resp_ready_o, mem_data_resp_ready_o}),
        DCMDW'({exp_fail || exp_errs > 0, 16'(exp_errs), 5'b0}));
    chk({tag, "_all_cmds_seen"}, DCMDW'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  initial begin : main
    int n;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_data_cmd", mem_data_cmd_o, '0);
    chk("reset_ctrl", DCMDW'({mem_cmd_o, mem_cmd_v_o, mem_data_cmd_v_o, mem_resp_ready_o,
                              mem_data_resp_ready_o, busy_o, done_o, error_o, err_cnt_o}), '0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_not_ready", DCMDW'({mem_resp_ready_o, mem_data_resp_ready_o, busy_o}), '0);

    run_once("clean", NOPS, NOPS, 0, 0, 0);

    corrupt_blk = 2;
    run_once("corrupt_blk2", NOPS, NOPS, 0, 1, 0);
    corrupt_blk = -1;

    stall_op0 = 1; rand_en = 0;
    run_once("stall_op0", NOPS, NOPS, 0, 0, 0);
    stall_op0 = 0; rand_en = 1;

    drop_op = 1;
    run_once("drop_ack", 2, 0, 1, 0, 0);
    chk("timeout_wait_cycles", DCMDW'(last_wait), DCMDW'(TMO));
    drop_op = -1;

    // Abort in the middle of RD_WAIT of op 2.
    push_expect(NOPS, NOPS);
    rd_hs = 0;
    pulse_start();
    n = 0;
    while (!(rd_hs >= 3 && mem_data_resp_ready_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_wait_op2", DCMDW'(mem_data_resp_ready_o), DCMDW'(1));
    rst_n = 0;
    #1;
    chk("abort_data_cmd", mem_data_cmd_o, '0);
    chk("abort_ctrl", DCMDW'({mem_cmd_o, mem_cmd_v_o, mem_data_cmd_v_o, mem_resp_ready_o,
                              mem_data_resp_ready_o, busy_o, done_o, error_o, err_cnt_o}), '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_abort_idle", DCMDW'({mem_cmd_v_o, mem_data_cmd_v_o, busy_o}), '0);
    run_once("after_reset", NOPS, NOPS, 0, 0, 0);

    run_once("start_while_busy", NOPS, NOPS, 0, 0, 1);
    run_once("back_to_back", NOPS, NOPS, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
